// File: rtl/fb_id_ex_reg_pkg.sv
// Shared types for the Firebird ID/EX stage: register-index width, ALU class
// encodings and the bit ordering of the decode control bundle.
package fb_id_ex_reg_pkg;

    localparam int REG_IDX_W = 5;
    localparam int FUNCT_W   = 4;
    localparam int ALU_OP_W  = 2;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_OP_LDST   = 2'b00,
        ALU_OP_BRANCH = 2'b01,
        ALU_OP_R      = 2'b10,
        ALU_OP_IARITH = 2'b11
    } alu_op_e;

    // MSB-first order matches the {alu_src ... jalr_en} port listing
    typedef struct packed {
        logic alu_src;
        logic alu_res_src;
        logic mem_read;
        logic mem_write;
        logic branch;
        logic mem_to_reg;
        logic reg_write;
        logic jalr_en;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/fb_id_ex_reg_hazard_detect.sv
// Load-use hazard compare: a load sitting in EX whose destination feeds either
// source index of the instruction currently in ID.
module fb_hazard_detect
    import fb_id_ex_reg_pkg::*;
(
    input  logic                 i_ex_valid,
    input  logic                 i_ex_mem_read,
    input  logic [REG_IDX_W-1:0] i_ex_rd,
    input  logic                 i_id_valid,
    input  logic [REG_IDX_W-1:0] i_id_rs1,
    input  logic [REG_IDX_W-1:0] i_id_rs2,
    output logic                 o_load_use
);

    logic w_rd_nonzero;
    logic w_src_match;

    // rs2 is compared even for I-type; the occasional spurious stall is tolerated
    assign w_rd_nonzero = (i_ex_rd != '0);
    assign w_src_match  = (i_ex_rd == i_id_rs1) | (i_ex_rd == i_id_rs2);
    assign o_load_use   = i_ex_valid & i_ex_mem_read & w_rd_nonzero & i_id_valid & w_src_match;

endmodule

// File: rtl/fb_id_ex_reg.sv
// ID/EX pipeline register with load-use stall/bubble insertion, flush and
// downstream hold handling, plus a saturating bubble counter.
module fb_id_ex_reg
    import fb_id_ex_reg_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [PC_W-1:0]      id_pc,
    input  logic [XLEN-1:0]      id_rs1_data,
    input  logic [XLEN-1:0]      id_rs2_data,
    input  logic [XLEN-1:0]      id_imm,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic [REG_IDX_W-1:0] id_rd,
    input  logic [FUNCT_W-1:0]   id_funct,
    input  logic [ALU_OP_W-1:0]  id_alu_op,
    input  logic                 id_alu_src,
    input  logic                 id_alu_res_src,
    input  logic                 id_mem_read,
    input  logic                 id_mem_write,
    input  logic                 id_branch,
    input  logic                 id_mem_to_reg,
    input  logic                 id_reg_write,
    input  logic                 id_jalr_en,
    input  logic                 flush,
    input  logic                 ex_hold,
    output logic                 ex_valid,
    output logic [PC_W-1:0]      ex_pc,
    output logic [XLEN-1:0]      ex_rs1_data,
    output logic [XLEN-1:0]      ex_rs2_data,
    output logic [XLEN-1:0]      ex_imm,
    output logic [REG_IDX_W-1:0] ex_rs1,
    output logic [REG_IDX_W-1:0] ex_rs2,
    output logic [REG_IDX_W-1:0] ex_rd,
    output logic [FUNCT_W-1:0]   ex_funct,
    output logic [ALU_OP_W-1:0]  ex_alu_op,
    output logic                 ex_alu_src,
    output logic                 ex_alu_res_src,
    output logic                 ex_mem_read,
    output logic                 ex_mem_write,
    output logic                 ex_branch,
    output logic                 ex_mem_to_reg,
    output logic                 ex_reg_write,
    output logic                 ex_jalr_en,
    output logic                 stall,
    output logic [CNT_W-1:0]     bubble_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic                 r_valid;
    logic [PC_W-1:0]      r_pc;
    logic [XLEN-1:0]      r_rs1_data;
    logic [XLEN-1:0]      r_rs2_data;
    logic [XLEN-1:0]      r_imm;
    logic [REG_IDX_W-1:0] r_rs1;
    logic [REG_IDX_W-1:0] r_rs2;
    logic [REG_IDX_W-1:0] r_rd;
    logic [FUNCT_W-1:0]   r_funct;
    logic [ALU_OP_W-1:0]  r_alu_op;
    ctrl_t                r_ctrl;
    logic [CNT_W-1:0]     r_bubble_cnt;

    ctrl_t w_id_ctrl;
    logic  w_load_use;
    logic  w_bubble;

    assign w_id_ctrl = {id_alu_src, id_alu_res_src, id_mem_read, id_mem_write,
                        id_branch, id_mem_to_reg, id_reg_write, id_jalr_en};

    fb_hazard_detect u_hazard (
        .i_ex_valid    (r_valid),
        .i_ex_mem_read (r_ctrl.mem_read),
        .i_ex_rd       (r_rd),
        .i_id_valid    (id_valid),
        .i_id_rs1      (id_rs1),
        .i_id_rs2      (id_rs2),
        .o_load_use    (w_load_use)
    );

    // A hold masks load-use, but a flush overrides the hold
    assign w_bubble = flush | (~ex_hold & w_load_use);
    assign stall    = w_load_use | ex_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_ctrl       <= CTRL_NOP;
            r_pc         <= '0;
            r_rs1_data   <= '0;
            r_rs2_data   <= '0;
            r_imm        <= '0;
            r_rs1        <= '0;
            r_rs2        <= '0;
            r_rd         <= '0;
            r_funct      <= '0;
            r_alu_op     <= '0;
            r_bubble_cnt <= '0;
        end else if (w_bubble) begin
            // Data fields are left stale; only validity and control are killed
            r_valid      <= 1'b0;
            r_ctrl       <= CTRL_NOP;
            r_bubble_cnt <= sat_inc(r_bubble_cnt);
        end else if (!ex_hold) begin
            r_valid    <= id_valid;
            r_ctrl     <= id_valid ? w_id_ctrl : CTRL_NOP;
            r_pc       <= id_pc;
            r_rs1_data <= id_rs1_data;
            r_rs2_data <= id_rs2_data;
            r_imm      <= id_imm;
            r_rs1      <= id_rs1;
            r_rs2      <= id_rs2;
            r_rd       <= id_rd;
            r_funct    <= id_funct;
            r_alu_op   <= id_alu_op;
        end
    end

    assign ex_valid       = r_valid;
    assign ex_pc          = r_pc;
    assign ex_rs1_data    = r_rs1_data;
    assign ex_rs2_data    = r_rs2_data;
    assign ex_imm         = r_imm;
    assign ex_rs1         = r_rs1;
    assign ex_rs2         = r_rs2;
    assign ex_rd          = r_rd;
    assign ex_funct       = r_funct;
    assign ex_alu_op      = r_alu_op;
    assign ex_alu_src     = r_ctrl.alu_src;
    assign ex_alu_res_src = r_ctrl.alu_res_src;
    assign ex_mem_read    = r_ctrl.mem_read;
    assign ex_mem_write   = r_ctrl.mem_write;
    assign ex_branch      = r_ctrl.branch;
    assign ex_mem_to_reg  = r_ctrl.mem_to_reg;
    assign ex_reg_write   = r_ctrl.reg_write;
    assign ex_jalr_en     = r_ctrl.jalr_en;
    assign bubble_cnt     = r_bubble_cnt;

endmodule

// File: tb/tb_fb_id_ex_reg.sv
// Self-checking bench for fb_id_ex_reg: directed scenarios plus randomized
// traffic against a behavioural model; a second instance uses a 4-bit counter.
module tb_fb_id_ex_reg;

    localparam int VW = 187;

    // control vector bit positions: [7]alu_src [6]alu_res_src [5]mem_read
    // [4]mem_write [3]branch [2]mem_to_reg [1]reg_write [0]jalr_en
    localparam logic [7:0] C_REGW = 8'b0000_0010;
    localparam logic [7:0] C_LOAD = 8'b1010_0110;

    logic        clk, rst, id_valid, flush, ex_hold;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [3:0]  id_funct;
    logic [1:0]  id_alu_op;
    logic [7:0]  id_ctrl;

    logic        ex_valid, stall;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [3:0]  ex_funct;
    logic [1:0]  ex_alu_op;
    logic [7:0]  ex_ctrl;
    logic [15:0] bubble_cnt;

    logic        b_valid, b_stall;
    logic [31:0] b_pc, b_rs1_data, b_rs2_data, b_imm;
    logic [4:0]  b_rs1, b_rs2, b_rd;
    logic [3:0]  b_funct;
    logic [1:0]  b_alu_op;
    logic [7:0]  b_ctrl;
    logic [3:0]  b_bubble_cnt;

    // reference model state
    logic        m_valid;
    logic [31:0] m_pc, m_rs1d, m_rs2d, m_imm;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [3:0]  m_funct;
    logic [1:0]  m_alu_op;
    logic [7:0]  m_ctrl;
    int          m_bubbles;

    int n_cmp = 0;
    int n_err = 0;

    fb_id_ex_reg dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct(id_funct),
        .id_alu_op(id_alu_op),
        .id_alu_src(id_ctrl[7]), .id_alu_res_src(id_ctrl[6]), .id_mem_read(id_ctrl[5]),
        .id_mem_write(id_ctrl[4]), .id_branch(id_ctrl[3]), .id_mem_to_reg(id_ctrl[2]),
        .id_reg_write(id_ctrl[1]), .id_jalr_en(id_ctrl[0]),
        .flush(flush), .ex_hold(ex_hold),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_funct(ex_funct), .ex_alu_op(ex_alu_op),
        .ex_alu_src(ex_ctrl[7]), .ex_alu_res_src(ex_ctrl[6]), .ex_mem_read(ex_ctrl[5]),
        .ex_mem_write(ex_ctrl[4]), .ex_branch(ex_ctrl[3]), .ex_mem_to_reg(ex_ctrl[2]),
        .ex_reg_write(ex_ctrl[1]), .ex_jalr_en(ex_ctrl[0]),
        .stall(stall), .bubble_cnt(bubble_cnt)
    );

    fb_id_ex_reg #(.XLEN(32), .PC_W(32), .CNT_W(4)) dut_c4 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct(id_funct),
        .id_alu_op(id_alu_op),
        .id_alu_src(id_ctrl[7]), .id_alu_res_src(id_ctrl[6]), .id_mem_read(id_ctrl[5]),
        .id_mem_write(id_ctrl[4]), .id_branch(id_ctrl[3]), .id_mem_to_reg(id_ctrl[2]),
        .id_reg_write(id_ctrl[1]), .id_jalr_en(id_ctrl[0]),
        .flush(flush), .ex_hold(ex_hold),
        .ex_valid(b_valid), .ex_pc(b_pc), .ex_rs1_data(b_rs1_data),
        .ex_rs2_data(b_rs2_data), .ex_imm(b_imm), .ex_rs1(b_rs1), .ex_rs2(b_rs2),
        .ex_rd(b_rd), .ex_funct(b_funct), .ex_alu_op(b_alu_op),
        .ex_alu_src(b_ctrl[7]), .ex_alu_res_src(b_ctrl[6]), .ex_mem_read(b_ctrl[5]),
        .ex_mem_write(b_ctrl[4]), .ex_branch(b_ctrl[3]), .ex_mem_to_reg(b_ctrl[2]),
        .ex_reg_write(b_ctrl[1]), .ex_jalr_en(b_ctrl[0]),
        .stall(b_stall), .bubble_cnt(b_bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [VW-1:0] dut_vec();
        return {ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
                ex_funct, ex_alu_op, ex_ctrl, bubble_cnt, b_bubble_cnt, b_valid, b_ctrl};
    endfunction

    function automatic logic [VW-1:0] model_vec();
        logic [15:0] c16;
        logic [3:0]  c4;
        c16 = (m_bubbles > 65535) ? 16'hFFFF : 16'(m_bubbles);
        c4  = (m_bubbles > 15) ? 4'hF : 4'(m_bubbles);
        return {m_valid, m_pc, m_rs1d, m_rs2d, m_imm, m_rs1, m_rs2, m_rd,
                m_funct, m_alu_op, m_ctrl, c16, c4, m_valid, m_ctrl};
    endfunction

    // a load in EX feeding either source of a real ID instruction
    function automatic logic exp_stall();
        logic lu;
        lu = m_valid && m_ctrl[5] && (m_rd != 5'd0) && id_valid &&
             ((m_rd == id_rs1) || (m_rd == id_rs2));
        return lu || ex_hold;
    endfunction

    task automatic rand_id(input int idx_max);
        id_valid    = ($urandom_range(0, 3) != 0);
        id_pc       = $urandom;
        id_rs1_data = $urandom;
        id_rs2_data = $urandom;
        id_imm      = $urandom;
        id_rs1      = 5'($urandom_range(0, idx_max));
        id_rs2      = 5'($urandom_range(0, idx_max));
        id_rd       = 5'($urandom_range(0, idx_max));
        id_funct    = 4'($urandom);
        id_alu_op   = 2'($urandom);
        id_ctrl     = 8'($urandom);
        if ($urandom_range(0, 1) == 1) id_ctrl[5] = 1'b1;
    endtask

    task automatic set_instr(input logic [31:0] pc, input logic [4:0] rd, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [1:0] op, input logic [7:0] ctrl);
        id_valid = 1'b1; id_pc = pc; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
        id_alu_op = op; id_ctrl = ctrl;
        id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom; id_funct = 4'($urandom);
    endtask

    // advance one clock, updating the model from the inputs seen at the edge
    task automatic tick();
        logic lu;
        lu = exp_stall() && !ex_hold;
        if (rst) begin
            m_valid = 0; m_ctrl = 0; m_pc = 0; m_rs1d = 0; m_rs2d = 0; m_imm = 0;
            m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_funct = 0; m_alu_op = 0; m_bubbles = 0;
        end else if (flush || (!ex_hold && lu)) begin
            m_valid = 0; m_ctrl = 0; m_bubbles++;
        end else if (!ex_hold) begin
            m_valid = id_valid; m_ctrl = id_valid ? id_ctrl : 8'h00;
            m_pc = id_pc; m_rs1d = id_rs1_data; m_rs2d = id_rs2_data; m_imm = id_imm;
            m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd; m_funct = id_funct; m_alu_op = id_alu_op;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; flush = 0; ex_hold = 0;
        for (int i = 0; i < 2; i++) begin
            rand_id(31);
            tick();
        end
        n_cmp++;
        if (ex_valid !== 1'b0 || ex_ctrl !== 8'h00 || bubble_cnt !== 16'd0 || ex_rd !== 5'd0) begin
            n_err++;
            $display("FAIL reset_state: got valid=%b ctrl=%h cnt=%0d rd=%0d, want 0/00/0/0",
                     ex_valid, ex_ctrl, bubble_cnt, ex_rd);
        end
        #1;
        n_cmp++;
        if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", stall); end
        n_cmp++;
        if (dut_vec() !== model_vec()) begin
            n_err++; $display("FAIL reset_vec: got %h want %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_pass_through();
        rst = 0;
        set_instr(32'h40, 5'd3, 5'd1, 5'd2, 2'b10, C_REGW);
        #1;
        n_cmp++;
        if (stall !== exp_stall()) begin n_err++; $display("FAIL pass_stall: got %b want %b", stall, exp_stall()); end
        tick();
        n_cmp++;
        if (ex_valid !== 1'b1 || ex_rd !== 5'd3 || ex_alu_op !== 2'b10 || ex_pc !== 32'h40 ||
            ex_ctrl !== C_REGW) begin
            n_err++;
            $display("FAIL pass_fields: got valid=%b rd=%0d op=%b pc=%h ctrl=%h, want 1/3/10/40/%h",
                     ex_valid, ex_rd, ex_alu_op, ex_pc, ex_ctrl, C_REGW);
        end
        n_cmp++;
        if (dut_vec() !== model_vec()) begin
            n_err++; $display("FAIL pass_vec: got %h want %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_load_use();
        set_instr(32'h44, 5'd5, 5'd1, 5'd0, 2'b00, C_LOAD);
        tick();
        set_instr(32'h48, 5'd6, 5'd5, 5'd1, 2'b11, C_REGW | 8'h80);
        #1;
        n_cmp++;
        if (stall !== 1'b1) begin n_err++; $display("FAIL lu_stall_hi: got %b want 1", stall); end
        tick();
        n_cmp++;
        if (ex_valid !== 1'b0 || ex_ctrl !== 8'h00 || bubble_cnt !== 16'd1) begin
            n_err++;
            $display("FAIL lu_bubble: got valid=%b ctrl=%h cnt=%0d, want 0/00/1", ex_valid, ex_ctrl, bubble_cnt);
        end
        #1;
        n_cmp++;
        if (stall !== 1'b0) begin n_err++; $display("FAIL lu_stall_lo: got %b want 0", stall); end
        tick();
        n_cmp++;
        if (ex_valid !== 1'b1 || ex_rd !== 5'd6 || ex_pc !== 32'h48 || bubble_cnt !== 16'd1) begin
            n_err++;
            $display("FAIL lu_replay: got valid=%b rd=%0d pc=%h cnt=%0d, want 1/6/48/1",
                     ex_valid, ex_rd, ex_pc, bubble_cnt);
        end
    endtask

    task automatic test_no_hazard();
        set_instr(32'h50, 5'd0, 5'd2, 5'd3, 2'b00, C_LOAD);
        tick();
        set_instr(32'h54, 5'd8, 5'd0, 5'd0, 2'b10, C_REGW);
        #1;
        n_cmp++;
        if (stall !== 1'b0) begin n_err++; $display("FAIL x0_stall: got %b want 0", stall); end
        tick();
        set_instr(32'h58, 5'd5, 5'd4, 5'd0, 2'b00, C_LOAD);
        tick();
        set_instr(32'h5C, 5'd7, 5'd1, 5'd2, 2'b10, C_REGW);
        #1;
        n_cmp++;
        if (stall !== 1'b0) begin n_err++; $display("FAIL unrel_stall: got %b want 0", stall); end
        tick();
        n_cmp++;
        if (ex_valid !== 1'b1 || ex_rd !== 5'd7 || bubble_cnt !== 16'd1) begin
            n_err++;
            $display("FAIL unrel_pass: got valid=%b rd=%0d cnt=%0d, want 1/7/1", ex_valid, ex_rd, bubble_cnt);
        end
    endtask

    task automatic test_flush_hold();
        logic [VW-1:0] snap;
        flush = 1; ex_hold = 1;
        rand_id(31);
        #1;
        n_cmp++;
        if (stall !== 1'b1) begin n_err++; $display("FAIL fh_stall: got %b want 1", stall); end
        tick();
        n_cmp++;
        if (ex_valid !== 1'b0 || ex_ctrl !== 8'h00 || bubble_cnt !== 16'd2 || ex_rd !== 5'd7) begin
            n_err++;
            $display("FAIL flush_over_hold: got valid=%b ctrl=%h cnt=%0d rd=%0d, want 0/00/2/7",
                     ex_valid, ex_ctrl, bubble_cnt, ex_rd);
        end
        flush = 0; ex_hold = 0;
        set_instr(32'h60, 5'd9, 5'd1, 5'd1, 2'b01, 8'h08);
        tick();
        snap = model_vec();
        ex_hold = 1;
        for (int i = 0; i < 3; i++) begin
            rand_id(31);
            #1;
            n_cmp++;
            if (stall !== 1'b1) begin n_err++; $display("FAIL hold_stall[%0d]: got %b want 1", i, stall); end
            tick();
            n_cmp++;
            if (dut_vec() !== snap || ex_valid !== 1'b1) begin
                n_err++; $display("FAIL hold_frozen[%0d]: got %h want %h", i, dut_vec(), snap);
            end
        end
        ex_hold = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            rst     = ($urandom_range(0, 49) == 0);
            flush   = ($urandom_range(0, 7) == 0);
            ex_hold = ($urandom_range(0, 5) == 0);
            rand_id(3);
            #1;
            n_cmp++;
            if (stall !== exp_stall()) begin
                n_err++; $display("FAIL rand_stall[%0d]: got %b want %b", i, stall, exp_stall());
            end
            tick();
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_err++; $display("FAIL rand_vec[%0d]: got %h want %h", i, dut_vec(), model_vec());
            end
        end
        rst = 0; flush = 0; ex_hold = 0;
    endtask

    task automatic test_saturation();
        rst = 1; rand_id(31);
        tick();
        rst = 0; flush = 1;
        for (int i = 0; i < 20; i++) begin
            rand_id(31);
            tick();
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_err++; $display("FAIL sat_vec[%0d]: got %h want %h", i, dut_vec(), model_vec());
            end
        end
        n_cmp++;
        if (b_bubble_cnt !== 4'd15 || bubble_cnt !== 16'd20) begin
            n_err++;
            $display("FAIL sat_final: got cnt4=%0d cnt16=%0d, want 15/20", b_bubble_cnt, bubble_cnt);
        end
        flush = 0;
    endtask

    initial begin
        rst = 1; flush = 0; ex_hold = 0;
        rand_id(31);
        test_reset();
        test_pass_through();
        test_load_use();
        test_no_hazard();
        test_flush_hold();
        test_random();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
